// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell reused LSB-first over WIDTH clocks.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             b_bit;
  logic             last_step;
  logic [WIDTH-1:0] res_shift;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  function automatic logic fs_diff(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  assign d_bit     = fs_diff(sa[0], sb[0], borrow);
  assign b_bit     = fs_borrow(sa[0], sb[0], borrow);
  assign res_shift = {d_bit, res[WIDTH-1:1]};
  assign last_step = (cnt == CW'(WIDTH - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand shifters, borrow flop and step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            res    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          sa     <= {1'b0, sa[WIDTH-1:1]};
          sb     <= {1'b0, sb[WIDTH-1:1]};
          res    <= res_shift;
          borrow <= b_bit;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers change only on the final step so partial sums never show
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (state == RUN && last_step) begin
      diff <= res_shift;
      bout <= b_bit;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are shifted out of sa/sb, so keep copies for the overflow test
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (state == RUN && last_step)
        ovf <= (a_msb != b_msb) && (res_shift[WIDTH-1] != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8); checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [W-1:0] last_diff = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ovf(input string name, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
    chk(name, {31'd0, ovf}, {31'd0, exp});
`endif
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input logic [W-1:0] ed, input logic ebo,
                        input logic eov);
    int done_edge = -1;
    int busy_cnt  = 0;
    int done_cnt  = 0;
    logic [W-1:0] got_d  = '0;
    logic         got_bo = 1'b0;
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ia; b = ~ib; bin = ~ibin;
    if (busy) busy_cnt++;
    for (int k = 1; k <= W + 3; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (k == W - 1) chk({tag, "_diff_held"}, {24'd0, diff}, {24'd0, last_diff});
      if (done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = k;
          got_d  = diff;
          got_bo = bout;
          chk_ovf({tag, "_ovf"}, eov);
        end
      end
    end
    if (done_edge < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_latency"}, done_edge, W);
    chk({tag, "_busy_cycles"}, busy_cnt, W + 1);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_diff"}, {24'd0, got_d}, {24'd0, ed});
    chk({tag, "_bout"}, {31'd0, got_bo}, {31'd0, ebo});
    last_diff = ed;
  endtask

  initial begin
    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

    // Reset held with start asserted: nothing may begin
    rst_n = 1'b0; start = 1'b1; a = 8'h5A; b = 8'h23; bin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_diff", {24'd0, diff}, 32'd0);
      chk("rst_bout", {31'd0, bout}, 32'd0);
    end
    chk_ovf("rst_ovf", 1'b0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
             vecs[i].d, vecs[i].bo, vecs[i].ov);

    // Start pulsed during RUN must be ignored
    begin
      int dcnt = 0;
      logic [W-1:0] gd = '0;
      logic         gb = 1'b1;
      @(negedge clk);
      a = 8'h40; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= W + 3; k++) begin
        @(posedge clk); #1;
        if (k == 3) begin start = 1'b1; a = 8'h00; b = 8'hFF; end
        if (k == 4) start = 1'b0;
        if (done) begin dcnt++; gd = diff; gb = bout; end
      end
      chk("busyprot_done_pulses", dcnt, 1);
      chk("busyprot_diff", {24'd0, gd}, 32'h3F);
      chk("busyprot_bout", {31'd0, gb}, 32'd0);
      chk("busyprot_idle_after", {31'd0, busy}, 32'd0);
      last_diff = 8'h3F;
    end

    // Leave nonzero results so the asynchronous clear is visible
    run_op("pre_rst", 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);

    @(negedge clk);
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_diff", {24'd0, diff}, 32'd0);
    chk("midrst_bout", {31'd0, bout}, 32'd0);
    chk_ovf("midrst_ovf", 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_diff = '0;
    run_op("after_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial subtraction controller that time-shares one full-subtractor cell across a WIDTH-bit operand pair. It processes one bit per clock, LSB first, and keeps the running borrow in a flop. It accepts a start request, sequences WIDTH subtract steps, and presents the registered difference and final borrow with a one-cycle done pulse. It sits in the arithmetic-circuits area as the sequencing wrapper for the dataflow full-subtractor datapath.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin a subtraction; sampled only in IDLE
a  input  WIDTH  minuend; latched on accepted start
b  input  WIDTH  subtrahend; latched on accepted start
bin  input  1  initial borrow-in; latched on accepted start
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse; diff/bout valid
diff  output  WIDTH  registered difference a - b - bin (mod 2^WIDTH)
bout  output  1  final borrow-out

Behaviour:
- Clock/reset: single clock clk; rst_n asynchronous, active-low. Reset asserted at any time, including mid-RUN: state=IDLE, busy=0, done=0, diff=0, bout=0, internal shift registers, borrow flop and bit counter=0. The operation in progress is abandoned, with no partial result.
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, latch a->sa, b->sb, bin->borrow, cnt<=0, and go to RUN. With start=0, remain in IDLE. diff/bout keep their last values.
- RUN, each edge:
  - d = sa[0]^sb[0]^borrow.
  - bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow).
  - The result register shifts right with d entering at the MSB. sa and sb shift right. borrow<=bo. cnt<=cnt+1.
  - When cnt==WIDTH-1, go to DONE and load diff from the final shifted result and bout<=bo. diff and bout update only on this edge, never during intermediate steps.
- DONE: done=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- start is ignored in RUN and DONE (no queuing). A start held high across DONE is sampled in IDLE on the following edge, giving back-to-back ops with one idle cycle.
- Inputs a/b/bin may change freely after acceptance; they have no effect until the next accepted start.
- Latency: the start-sampling edge is edge 0. RUN steps occur on edges 1..WIDTH. DONE is entered on edge WIDTH. done is high in the cycle following edge WIDTH. Throughput is one op per WIDTH+2 cycles.
- cnt width: clog2(WIDTH) bits. No wrap is reachable, because the exit happens at WIDTH-1.
- Arithmetic: the result equals (a - b - bin) mod 2^WIDTH. bout=1 exactly when a < b + bin (unsigned).

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined: adds output port ovf (1 bit), the signed two's-complement overflow flag, computed as (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]).
  - Uses the latched operand MSBs.
  - Registered on the same edge as diff and held with it.
  - Reset value 0.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: assert rst_n=0 for 3 cycles with start=1 -> busy=0, done=0, diff=0x00, bout=0 throughout; no operation starts.
2. WIDTH=8; a=0x5A, b=0x23, bin=0, start pulsed 1 cycle -> busy high for 9 cycles; done high exactly one cycle after edge 8; diff=0x37, bout=0.
3. Borrow cases:
   - a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
   - a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
   - a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
4. Busy protection: start a=0x40, b=0x01; at RUN cycle 3 pulse start with a=0x00, b=0xFF -> second request ignored; diff=0x3F, bout=0; only one done pulse.
5. Mid-op reset: start a=0x80, b=0x01; drop rst_n at RUN cycle 4 -> busy, done, diff and bout go to 0 immediately, without waiting for a clock. After release, start a=0x09, b=0x04 -> diff=0x05, bout=0.
6. With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x05, b=0x03 -> diff=0x02, ovf=0.
